// File: rtl/nacifra_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nacifra_pkg
// Purpose  : Nacifra code constants, segment patterns and scan FSM states.
// Revision : 1.0
// ============================================================================
package nacifra_pkg;

  typedef logic [4:0] nacifra_t;

  localparam nacifra_t NACIFRA_0 = 5'b00000;
  localparam nacifra_t NACIFRA_1 = 5'b10000;
  localparam nacifra_t NACIFRA_2 = 5'b11000;
  localparam nacifra_t NACIFRA_3 = 5'b11100;
  localparam nacifra_t NACIFRA_4 = 5'b11110;
  localparam nacifra_t NACIFRA_5 = 5'b11111;
  localparam nacifra_t NACIFRA_6 = 5'b01111;
  localparam nacifra_t NACIFRA_7 = 5'b00111;
  localparam nacifra_t NACIFRA_8 = 5'b00011;
  localparam nacifra_t NACIFRA_9 = 5'b00001;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  function automatic logic is_legal_code(input nacifra_t code);
    case (code)
      NACIFRA_0, NACIFRA_1, NACIFRA_2, NACIFRA_3, NACIFRA_4,
      NACIFRA_5, NACIFRA_6, NACIFRA_7, NACIFRA_8, NACIFRA_9: is_legal_code = 1'b1;
      default:                                               is_legal_code = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/nacifra_seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : nacifra_seg_decode
// Purpose  : Combinational Nacifra code to active-low 7-segment pattern map.
// Revision : 1.0
// ============================================================================
module nacifra_seg_decode
  import nacifra_pkg::*;
(
  input  nacifra_t   code,
  output logic [6:0] seg_n
);

  always_comb begin
    case (code)
      NACIFRA_0: seg_n = 7'b1000000;
      NACIFRA_1: seg_n = 7'b1111001;
      NACIFRA_2: seg_n = 7'b0100100;
      NACIFRA_3: seg_n = 7'b0110000;
      NACIFRA_4: seg_n = 7'b0011001;
      NACIFRA_5: seg_n = 7'b0010010;
      NACIFRA_6: seg_n = 7'b0000010;
      NACIFRA_7: seg_n = 7'b1111000;
      NACIFRA_8: seg_n = 7'b0000000;
      NACIFRA_9: seg_n = 7'b0010000;
      default:   seg_n = SEG_ERR;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/nacifra_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nacifra_scan_ctrl
// Purpose  : Double-buffered multiplexed 7-segment scan controller.
//            NACIFRA_CODE_CHECK_EN adds illegal-code filtering and code_err.
// Revision : 1.0
// ============================================================================
module nacifra_scan_ctrl
  import nacifra_pkg::*;
#(
  parameter  int NUM_DIGITS  = 4,
  parameter  int SHOW_CYCLES = 50000,
  parameter  int GAP_CYCLES  = 500,
  localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [4:0]            wr_code,
  input  logic                  commit_req,
  output logic                  commit_pending,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
`ifdef NACIFRA_CODE_CHECK_EN
  output logic                  code_err,
`endif
  output logic                  frame_done
);

  localparam int TMR_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] C_SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] C_GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [TMR_W-1:0]      r_timer;
  nacifra_t              r_shadow [NUM_DIGITS];
  nacifra_t              r_active [NUM_DIGITS];
  logic                  r_commit_pending;
  logic [6:0]            r_seg_n;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic                  r_frame_done;

  logic       w_wr_fire;
  logic       w_wr_store;
  logic       w_boundary;
  logic [6:0] w_dec_seg;

  assign w_wr_fire  = wr_valid & ~r_commit_pending;
  assign w_boundary = en && (r_state == GAP) && (r_timer == C_GAP_LAST) && (r_idx == C_IDX_LAST);

`ifdef NACIFRA_CODE_CHECK_EN
  logic r_code_err;

  assign w_wr_store = w_wr_fire & is_legal_code(wr_code);
  assign code_err   = r_code_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code_err <= 1'b0;
    end else if (w_wr_fire) begin
      r_code_err <= ~is_legal_code(wr_code);
    end
  end
`else
  assign w_wr_store = w_wr_fire;
`endif

  // Out-of-range addresses match no digit, so such writes fall away here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_wr_store && (wr_addr == IDX_W'(i))) r_shadow[i] <= wr_code;
        if (w_boundary && r_commit_pending)       r_active[i] <= r_shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_pending <= 1'b0;
    end else if (w_boundary && r_commit_pending) begin
      r_commit_pending <= 1'b0;
    end else if (!r_commit_pending && commit_req) begin
      r_commit_pending <= 1'b1;
    end
  end

  nacifra_seg_decode u_seg_decode (
    .code  (r_active[r_idx]),
    .seg_n (w_dec_seg)
  );

  // Outputs are decoded from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_timer      <= '0;
      r_seg_n      <= SEG_BLANK;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (r_state == SHOW) begin
        r_an_n  <= ~(NUM_DIGITS'(1) << r_idx);
        r_seg_n <= w_dec_seg;
      end else begin
        r_an_n  <= '1;
        r_seg_n <= SEG_BLANK;
      end

      if (!en) begin
        r_state <= IDLE;
        r_idx   <= '0;
        r_timer <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= SHOW;
            r_timer <= '0;
          end
          SHOW: begin
            if (r_timer == C_SHOW_LAST) begin
              r_state <= GAP;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + TMR_W'(1);
            end
          end
          GAP: begin
            if (r_timer == C_GAP_LAST) begin
              r_state <= SHOW;
              r_timer <= '0;
              r_idx   <= (r_idx == C_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
              r_timer <= r_timer + TMR_W'(1);
            end
          end
          default: begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_timer <= '0;
          end
        endcase
      end
    end
  end

  assign wr_ready       = ~r_commit_pending;
  assign commit_pending = r_commit_pending;
  assign seg_n          = r_seg_n;
  assign an_n           = r_an_n;
  assign frame_done     = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_nacifra_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nacifra_scan_ctrl
// Purpose  : Scoreboard bench for nacifra_scan_ctrl (4 digits, 4 show, 2 gap).
// Revision : 1.0
// ============================================================================
module tb_nacifra_scan_ctrl;

  localparam int ND    = 4;
  localparam int SC    = 4;
  localparam int GC    = 2;
  localparam int FRAME = ND * (SC + GC);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [4:0] wr_code = 5'd0;
  logic       commit_req = 1'b0;
  logic       wr_ready;
  logic       commit_pending;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       frame_done;
`ifdef NACIFRA_CODE_CHECK_EN
  logic       code_err;
`endif

  nacifra_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SHOW_CYCLES (SC),
    .GAP_CYCLES  (GC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_code        (wr_code),
    .commit_req     (commit_req),
    .commit_pending (commit_pending),
    .seg_n          (seg_n),
    .an_n           (an_n),
`ifdef NACIFRA_CODE_CHECK_EN
    .code_err       (code_err),
`endif
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_decode(input logic [4:0] c);
    case (c)
      5'b10000: ref_decode = 7'b1111001;
      5'b11000: ref_decode = 7'b0100100;
      5'b11100: ref_decode = 7'b0110000;
      5'b11110: ref_decode = 7'b0011001;
      5'b11111: ref_decode = 7'b0010010;
      5'b01111: ref_decode = 7'b0000010;
      5'b00111: ref_decode = 7'b1111000;
      5'b00011: ref_decode = 7'b0000000;
      5'b00001: ref_decode = 7'b0010000;
      5'b00000: ref_decode = 7'b1000000;
      default:  ref_decode = 7'b0000110;
    endcase
  endfunction

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] disp_code [ND];

  task automatic push_frame();
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      e.an  = ~(4'b0001 << d);
      e.seg = ref_decode(disp_code[d]);
      exp_q.push_back(e);
    end
  endtask

  // Output monitor: pops one expectation at the start of every lit digit.
  logic       mon_on = 1'b0;
  logic       m_lit;
  logic       prev_lit;
  bit         seen_lit;
  bit         seen_fd;
  int         run_len;
  int         fd_cnt;
  logic [6:0] hold_seg;
  exp_t       m_exp;

  always @(negedge clk) begin
    if (!mon_on || !rst_n) begin
      prev_lit = 1'b0;
      seen_lit = 1'b0;
      seen_fd  = 1'b0;
      run_len  = 0;
      fd_cnt   = 0;
    end else begin
      m_lit = (an_n !== 4'hF);
      if (m_lit != prev_lit) begin
        if (prev_lit)      check_eq("show_len", run_len, SC);
        else if (seen_lit) check_eq("gap_len", run_len, GC);
        run_len = 1;
      end else begin
        run_len++;
      end
      if (m_lit && !prev_lit) begin
        seen_lit = 1'b1;
        hold_seg = seg_n;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_digit", 32'(an_n), 32'hF);
        end else begin
          m_exp = exp_q.pop_front();
          check_eq("anode", 32'(an_n), 32'(m_exp.an));
          check_eq("seg", 32'(seg_n), 32'(m_exp.seg));
        end
      end else if (m_lit) begin
        check_eq("seg_hold", 32'(seg_n), 32'(hold_seg));
      end else begin
        check_eq("blank_seg", 32'(seg_n), 32'h7F);
      end
      prev_lit = m_lit;
      fd_cnt++;
      if (frame_done) begin
        if (seen_fd) check_eq("frame_period", fd_cnt, FRAME);
        seen_fd = 1'b1;
        fd_cnt  = 0;
      end
    end
  end

  task automatic wait_fd(input string tag);
    int k = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(frame_done), 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] pat, input string tag);
    int k = 0;
    @(negedge clk);
    while (an_n !== pat && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(an_n), 32'(pat));
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic write_digit(input logic [1:0] a, input logic [4:0] c);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_code  = c;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_seg", 32'(seg_n), 32'h7F);
    check_eq("rst_an", 32'(an_n), 32'hF);
    check_eq("rst_fd", 32'(frame_done), 32'd0);
    check_eq("rst_pending", 32'(commit_pending), 32'd0);
    check_eq("rst_ready", 32'(wr_ready), 32'd1);
`ifdef NACIFRA_CODE_CHECK_EN
    check_eq("rst_code_err", 32'(code_err), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_dark", 32'(an_n), 32'hF);

    // Scan of cleared banks, then double-buffered update
    for (int d = 0; d < ND; d++) disp_code[d] = 5'b00000;
    push_frame();
    mon_on = 1'b1;
    en     = 1'b1;
    wait_fd("fd_first");
    push_frame();
    write_digit(2'd0, 5'b11000);
    write_digit(2'd1, 5'b10000);
    write_digit(2'd2, 5'b00011);
    write_digit(2'd3, 5'b11111);
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    check_eq("pending_set", 32'(commit_pending), 32'd1);
    check_eq("ready_low", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1;
    wr_addr  = 2'd0;
    wr_code  = 5'b11111;
    repeat (3) @(negedge clk);
    check_eq("ready_blocked", 32'(wr_ready), 32'd0);
    wr_valid = 1'b0;
    wait_fd("fd_commit");
    check_eq("pending_clr", 32'(commit_pending), 32'd0);
    check_eq("ready_back", 32'(wr_ready), 32'd1);
    disp_code[0] = 5'b11000;
    disp_code[1] = 5'b10000;
    disp_code[2] = 5'b00011;
    disp_code[3] = 5'b11111;
    push_frame();

    // Illegal code write; commit request landing on the boundary edge
    write_digit(2'd1, 5'b10101);
`ifdef NACIFRA_CODE_CHECK_EN
    check_eq("code_err_set", 32'(code_err), 32'd1);
`endif
    write_digit(2'd3, 5'b00111);
`ifdef NACIFRA_CODE_CHECK_EN
    check_eq("code_err_clr", 32'(code_err), 32'd0);
`endif
    repeat (21) @(negedge clk);
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    check_eq("boundary_hit", 32'(frame_done), 32'd1);
    check_eq("late_commit_pending", 32'(commit_pending), 32'd1);
    push_frame();
    wait_fd("fd_late_commit");
    check_eq("late_commit_clr", 32'(commit_pending), 32'd0);
`ifdef NACIFRA_CODE_CHECK_EN
    disp_code[1] = 5'b10000;
`else
    disp_code[1] = 5'b10101;
`endif
    disp_code[3] = 5'b00111;
    push_frame();

    // Disable mid-show of digit 2, then restart from digit 0
    wait_an(4'b1011, "reach_digit2");
    mon_on = 1'b0;
    exp_q.delete();
    en = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("en_off_an", 32'(an_n), 32'hF);
    check_eq("en_off_seg", 32'(seg_n), 32'h7F);
    repeat (3) @(negedge clk);
    push_frame();
    mon_on = 1'b1;
    en     = 1'b1;

    // Asynchronous reset in a gap with a commit outstanding
    wait_fd("fd_restart");
    push_frame();
    write_digit(2'd0, 5'b11111);
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    check_eq("pend_before_rst", 32'(commit_pending), 32'd1);
    wait_an(4'b1110, "reach_digit0");
    wait_an(4'hF, "reach_gap");
    mon_on = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_seg", 32'(seg_n), 32'h7F);
    check_eq("mid_rst_an", 32'(an_n), 32'hF);
    check_eq("mid_rst_fd", 32'(frame_done), 32'd0);
    check_eq("mid_rst_pending", 32'(commit_pending), 32'd0);
    @(negedge clk);
    for (int d = 0; d < ND; d++) disp_code[d] = 5'b00000;
    push_frame();
    mon_on = 1'b1;
    rst_n  = 1'b1;
    drain("post_rst_drain");
    wait_fd("fd_final");
    mon_on = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nacifra_scan_ctrl.md
Name: nacifra_scan_ctrl

Overview:
- Time-multiplexed display controller for NUM_DIGITS common-anode 7-segment digits that share one segment bus.
- Holds one 5-bit Nacifra code per digit in a double-buffered register bank.
- Scans the digits one at a time, with a blanking gap between digits, and drives the active-low segment and anode lines.
- Sits between the Caesar-cipher datapath, which writes digits, and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2)
SHOW_CYCLES, 50000, clock cycles each digit is lit (>=1)
GAP_CYCLES, 500, clock cycles all anodes are off between digits (>=1)
IDX_W, $clog2(NUM_DIGITS), digit index width (derived, localparam)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 = display dark
wr_valid  in  1  shadow-bank write request
wr_ready  out  1  shadow bank can accept a write
wr_addr  in  IDX_W  digit to write
wr_code  in  5  Nacifra code {s5..s1}
commit_req  in  1  pulse; copy shadow to active at next frame boundary
commit_pending  out  1  commit requested, not yet applied
seg_n  out  7  active-low segments {d7..d1}, seg_n[6]=d7
an_n  out  NUM_DIGITS  active-low anodes, one-hot-low when lit
frame_done  out  1  1-cycle pulse at end of each frame

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - seg_n=7'h7F, an_n=all 1s, frame_done=0, commit_pending=0.
  - Digit index=0, timer=0, state=IDLE.
  - Both banks hold 5'b00000 in every digit.
- wr_ready = ~commit_pending.
- Writes:
  - A write happens when wr_valid & wr_ready. It stores wr_code into shadow[wr_addr] at that edge.
  - wr_addr >= NUM_DIGITS is accepted and discarded.
- commit_req:
  - When commit_pending=0, commit_req sets commit_pending=1 on the next edge.
  - When commit_pending=1, commit_req is ignored.
- FSM states: IDLE, SHOW, GAP.
  - IDLE:
    - an_n all 1s, seg_n=7'h7F, index=0, timer=0.
    - When en=1, go to SHOW next cycle.
  - SHOW:
    - an_n[index]=0, all other anode bits 1.
    - seg_n = decode(active[index]).
    - The timer counts 0..SHOW_CYCLES-1. At the terminal count, go to GAP with timer=0.
  - GAP:
    - an_n all 1s, seg_n=7'h7F.
    - The timer counts 0..GAP_CYCLES-1. At the terminal count:
      - If index==NUM_DIGITS-1, this is a frame boundary: index wraps to 0 and frame_done=1 for 1 cycle.
      - Otherwise index increments.
    - Then go to SHOW.
- Frame boundary commit:
  - If commit_pending=1 at the frame-boundary edge, active<=shadow for all digits and commit_pending<=0.
  - A commit_req arriving in the boundary cycle itself (pending was 0) waits for the following boundary.
- en deasserted in any state: go to IDLE at the next edge. Index and timer reset, commit_pending is held.
- Output timing:
  - seg_n, an_n and frame_done are registered: they change one cycle after the state or index change.
  - Anodes and segments always switch on the same edge, so there is no ghosting.
- Decode table (code -> seg_n):
  - 10000->1111001, 11000->0100100, 11100->0110000, 11110->0011001, 11111->0010010
  - 01111->0000010, 00111->1111000, 00011->0000000, 00001->0010000, 00000->1000000
  - any other code -> 0000110
- Reset mid-frame: outputs go to their reset values immediately; both banks are cleared.

Optional Feature:
Macro: NACIFRA_CODE_CHECK_EN
- Defined:
  - A write whose wr_code is not one of the 10 legal codes is still handshaken (wr_ready unaffected) but does not modify shadow.
  - Extra output port code_err (1 bit) is sticky-set on such a write.
  - code_err is cleared by reset, or by a legal write in the same cycle it would otherwise stay set.
- Undefined: port code_err is absent; every code is stored and illegal codes display 0000110.

Decomposition:
- Package nacifra_pkg holds:
  - typedef nacifra_t (logic [4:0]) and the 10 legal code constants.
  - SEG_BLANK=7'h7F and SEG_ERR=7'b0000110.
  - FSM state enum scan_state_t {IDLE, SHOW, GAP}.
  - function is_legal_code().
- Sub-module nacifra_seg_decode: purely combinational code->seg_n map, instantiated once on active[index].

Test Plan (NUM_DIGITS=4, SHOW_CYCLES=4, GAP_CYCLES=2, frame = 24 cycles):
- Reset, en=1: an_n sequence 1110 x4 cycles, 1111 x2, 1101 x4, 1111 x2 … 0111, then back to 1110; every lit cycle shows seg_n=1000000 (code 00000); frame_done pulses once every 24 cycles.
- Write shadow={11000,10000,00011,11111}, then commit_req: display unchanged until the next frame_done; following frame shows digit0=0100100, digit1=1111001, digit2=0000000, digit3=0010010.
- During commit_pending=1, wr_valid=1: wr_ready=0, write ignored; wr_ready returns to 1 the cycle after the boundary.
- Write 10101 to digit 1 and commit: digit 1 shows 0000110 (macro undefined); with NACIFRA_CODE_CHECK_EN, digit 1 keeps its old code and code_err=1.
- Deassert en mid-SHOW of digit 2: next cycle IDLE, all anodes dark; after re-enable, scanning restarts at digit 0.
- Assert rst_n=0 mid-GAP with commit pending: outputs go to their reset values asynchronously and commit_pending=0; after release the display shows 1000000 on all digits.
